// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//
// Pipeline stage register for an inter-stage boundary (IF/ID, ID/EX, EX/MEM,
// MEM/WB). It uses a valid/ready handshake and holds up to two entries: a main
// entry that drives out_data and a skid entry that catches one extra word
// when downstream stops accepting. Several stall sources are OR-reduced and
// freeze the stage. A synchronous flush empties the stage and loads the
// bubble image. A saturating counter records how many cycles the stage spent
// stalled.
//
// Parameters
//   DATA_W     payload width in bits
//   N_STALL    number of independent stall request inputs
//   FLUSH_VAL  payload image after reset or flush (bubble / NOP)
//   CNT_W      width of the stall-cycle counter
//
// Ports
//   clock         in   rising-edge clock
//   reset         in   asynchronous reset, active low
//   in_valid      in   upstream offers in_data this cycle
//   in_data       in   upstream payload [DATA_W]
//   in_ready      out  stage accepts in_data this cycle
//   stall         in   stall requests [N_STALL]; any bit high freezes the stage
//   flush         in   discard all held entries at the next clock edge
//   out_valid     out  out_data holds a valid entry
//   out_data      out  payload of the oldest held entry [DATA_W]
//   out_ready     in   downstream accepts out_data this cycle
//   stall_cycles  out  saturating count of cycles with any stall bit high
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
  parameter int unsigned             DATA_W    = 96,
  parameter int unsigned             N_STALL   = 2,
  parameter logic [DATA_W-1:0]       FLUSH_VAL = {DATA_W{1'b0}},
  parameter int unsigned             CNT_W     = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  in_data,
  output logic               in_ready,
  input  logic [N_STALL-1:0] stall,
  input  logic               flush,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_data,
  input  logic               out_ready,
  output logic [CNT_W-1:0]   stall_cycles
);

  // Occupancy: EMPTY = no entries, ONE = main only, FULL = main + skid.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  main_q,  main_d;
  logic [DATA_W-1:0]  skid_q,  skid_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;

  logic stall_any;
  logic in_xfer;
  logic out_xfer;

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  assign stall_any = |stall;

  // in_ready depends only on the state register and stall/flush; keeping
  // out_ready out of this path stops ready chains from forming a long
  // combinational loop across stages. The skid entry is what makes that safe.
  assign in_ready  = ~stall_any & ~flush & (state_q != ST_FULL);
  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = main_q;

  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready & ~stall_any & ~flush;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default first, so no path leaves a value
    // unassigned and no latch can be inferred.
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    if (flush) begin
      // Flush wins over stall and over any input offered this cycle.
      state_d = ST_EMPTY;
      main_d  = FLUSH_VAL;
      skid_d  = FLUSH_VAL;
    end else if (!stall_any) begin
      unique case (state_q)
        ST_EMPTY: begin
          if (in_xfer) begin
            state_d = ST_ONE;
            main_d  = in_data;
          end
        end

        ST_ONE: begin
          if (in_xfer && out_xfer) begin
            // Pass-through: the new word replaces the departing one.
            main_d = in_data;
          end else if (in_xfer) begin
            state_d = ST_FULL;
            skid_d  = in_data;
          end else if (out_xfer) begin
            // main keeps its last value; out_valid masks it.
            state_d = ST_EMPTY;
          end
        end

        ST_FULL: begin
          // in_ready is low here, so only the output side can move.
          if (out_xfer) begin
            state_d = ST_ONE;
            main_d  = skid_q;
          end
        end

        default: begin
          state_d = ST_EMPTY;
          main_d  = FLUSH_VAL;
          skid_d  = FLUSH_VAL;
        end
      endcase
    end
  end

  // Stall counter counts every stalled edge, even when flush is also high.
  always_comb begin
    cnt_d = cnt_q;
    if (stall_any && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_EMPTY;
      // NOTE: the payload registers are reset too, so out_data shows the
      // bubble image straight out of reset instead of X.
      main_q  <= FLUSH_VAL;
      skid_q  <= FLUSH_VAL;
      cnt_q   <= '0;
    end else begin
      // NOTE: nonblocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign stall_cycles = cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_reg
//
// Directed bench for pipe_stage_reg. A table of per-cycle vectors covers
// streaming, backpressure, stall and flush. Hand-written sequences cover
// asynchronous reset mid-operation and counter saturation. Inputs are driven
// on the falling edge. Outputs are sampled 1 time unit later, which shows the
// state left by the previous rising edge.
// -----------------------------------------------------------------------------
module tb_pipe_stage_reg;

  localparam int unsigned       DATA_W  = 32;
  localparam int unsigned       N_STALL = 2;
  localparam int unsigned       CNT_W   = 4;
  localparam logic [DATA_W-1:0] FV      = 32'hDEAD_0013;

  logic               clock = 1'b0;
  logic               reset;
  logic               in_valid;
  logic [DATA_W-1:0]  in_data;
  logic               in_ready;
  logic [N_STALL-1:0] stall;
  logic               flush;
  logic               out_valid;
  logic [DATA_W-1:0]  out_data;
  logic               out_ready;
  logic [CNT_W-1:0]   stall_cycles;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  pipe_stage_reg #(
    .DATA_W    (DATA_W),
    .N_STALL   (N_STALL),
    .FLUSH_VAL (FV),
    .CNT_W     (CNT_W)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .stall        (stall),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_ready    (out_ready),
    .stall_cycles (stall_cycles)
  );

  // One cycle of stimulus. The expected values describe the outputs seen
  // before the rising edge that ends this cycle.
  typedef struct {
    logic               iv;
    logic [DATA_W-1:0]  d;
    logic [N_STALL-1:0] st;
    logic               fl;
    logic               ordy;
    logic               e_ir;
    logic               e_ov;
    logic [DATA_W-1:0]  e_od;
    logic [CNT_W-1:0]   e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic iv, input logic [DATA_W-1:0] d, input logic [N_STALL-1:0] st,
                     input logic fl, input logic ordy, input logic e_ir, input logic e_ov,
                     input logic [DATA_W-1:0] e_od, input logic [CNT_W-1:0] e_cnt);
    vec_t v;
    v.iv = iv; v.d = d; v.st = st; v.fl = fl; v.ordy = ordy;
    v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od; v.e_cnt = e_cnt;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic iv, input logic [DATA_W-1:0] d, input logic [N_STALL-1:0] st,
                       input logic fl, input logic ordy);
    in_valid  = iv;
    in_data   = d;
    stall     = st;
    flush     = fl;
    out_ready = ordy;
  endtask

  initial begin
    reset = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0);

    //   iv  data   stall  fl ordy | ir ov out_data  cnt
    // Streaming: 1..4 back to back, one per cycle, latency 1.
    add(1, 32'h1, 2'b00, 0, 1,    1, 0, FV,       0);   // v0
    add(1, 32'h2, 2'b00, 0, 1,    1, 1, 32'h1,    0);   // v1
    add(1, 32'h3, 2'b00, 0, 1,    1, 1, 32'h2,    0);   // v2
    add(1, 32'h4, 2'b00, 0, 1,    1, 1, 32'h3,    0);   // v3
    add(0, 32'h0, 2'b00, 0, 1,    1, 1, 32'h4,    0);   // v4
    add(0, 32'h0, 2'b00, 0, 1,    1, 0, 32'h4,    0);   // v5 empty, main holds
    // Backpressure into the skid entry.
    add(1, 32'hA, 2'b00, 0, 0,    1, 0, 32'h4,    0);   // v6 A accepted
    add(1, 32'hB, 2'b00, 0, 0,    1, 1, 32'hA,    0);   // v7 B into skid
    add(1, 32'hC, 2'b00, 0, 0,    0, 1, 32'hA,    0);   // v8 FULL, C held
    add(1, 32'hC, 2'b00, 0, 1,    0, 1, 32'hA,    0);   // v9 A leaves
    add(1, 32'hC, 2'b00, 0, 1,    1, 1, 32'hB,    0);   // v10 B leaves, C in
    add(0, 32'h0, 2'b00, 0, 1,    1, 1, 32'hC,    0);   // v11
    add(0, 32'h0, 2'b00, 0, 1,    1, 0, 32'hC,    0);   // v12
    // Stall freezes a ONE state holding 0x55.
    add(1, 32'h55, 2'b00, 0, 0,   1, 0, 32'hC,    0);   // v13
    add(1, 32'h66, 2'b10, 0, 1,   0, 1, 32'h55,   0);   // v14
    add(1, 32'h66, 2'b10, 0, 1,   0, 1, 32'h55,   1);   // v15
    add(1, 32'h66, 2'b10, 0, 1,   0, 1, 32'h55,   2);   // v16
    add(1, 32'h66, 2'b00, 0, 1,   1, 1, 32'h55,   3);   // v17 resumes
    add(0, 32'h0,  2'b00, 0, 0,   1, 1, 32'h66,   3);   // v18
    // Flush with stall from FULL (0x11, 0x22).
    add(0, 32'h0,  2'b00, 0, 1,   1, 1, 32'h66,   3);   // v19 drain
    add(1, 32'h11, 2'b00, 0, 0,   1, 0, 32'h66,   3);   // v20
    add(1, 32'h22, 2'b00, 0, 0,   1, 1, 32'h11,   3);   // v21
    add(1, 32'h33, 2'b01, 1, 1,   0, 1, 32'h11,   3);   // v22 flush + stall
    add(0, 32'h0,  2'b00, 0, 1,   1, 0, FV,       4);   // v23 bubble
    add(1, 32'h77, 2'b00, 0, 1,   1, 0, FV,       4);   // v24
    add(0, 32'h0,  2'b00, 0, 1,   1, 1, 32'h77,   4);   // v25 33 was dropped
    // Flush alone from ONE; counter must not move.
    add(1, 32'h88, 2'b00, 0, 0,   1, 0, 32'h77,   4);   // v26
    add(1, 32'h99, 2'b00, 1, 1,   0, 1, 32'h88,   4);   // v27 flush
    add(0, 32'h0,  2'b00, 0, 0,   1, 0, FV,       4);   // v28

    // Reset state while reset is held for two cycles.
    @(negedge clock);
    @(negedge clock);
    #1;
    check("rst out_valid",    64'(out_valid),    64'(0));
    check("rst out_data",     64'(out_data),     64'(FV));
    check("rst stall_cycles", 64'(stall_cycles), 64'(0));
    reset = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clock);
      drive(vecs[i].iv, vecs[i].d, vecs[i].st, vecs[i].fl, vecs[i].ordy);
      #1;
      check($sformatf("v%0d in_ready", i),     64'(in_ready),     64'(vecs[i].e_ir));
      check($sformatf("v%0d out_valid", i),    64'(out_valid),    64'(vecs[i].e_ov));
      check($sformatf("v%0d out_data", i),     64'(out_data),     64'(vecs[i].e_od));
      check($sformatf("v%0d stall_cycles", i), 64'(stall_cycles), 64'(vecs[i].e_cnt));
    end

    // Asynchronous reset while FULL, between clock edges.
    @(negedge clock); drive(1, 32'hAA, 2'b00, 0, 0);
    @(negedge clock); drive(1, 32'hBB, 2'b00, 0, 0);
    @(negedge clock); drive(0, 32'h0,  2'b00, 0, 0);
    #1;
    check("full in_ready",  64'(in_ready),  64'(0));
    check("full out_data",  64'(out_data),  64'(32'hAA));
    #1;
    reset = 1'b0;
    #1;
    check("async out_valid",    64'(out_valid),    64'(0));
    check("async out_data",     64'(out_data),     64'(FV));
    check("async stall_cycles", 64'(stall_cycles), 64'(0));
    check("async in_ready",     64'(in_ready),     64'(1));
    @(negedge clock);
    reset = 1'b1;
    // A fresh entry must come out alone; nothing left over from before reset.
    @(negedge clock); drive(1, 32'hCC, 2'b00, 0, 1);
    @(negedge clock); drive(0, 32'h0,  2'b00, 0, 1);
    #1;
    check("post-rst out_valid", 64'(out_valid), 64'(1));
    check("post-rst out_data",  64'(out_data),  64'(32'hCC));
    @(negedge clock);
    #1;
    check("post-rst drained", 64'(out_valid), 64'(0));

    // Counter saturation at 2^CNT_W - 1 = 15.
    drive(0, 32'h0, 2'b01, 0, 1);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clock);
      #1;
      check($sformatf("sat cnt %0d", i), 64'(stall_cycles), 64'((i > 15) ? 15 : i));
    end
    drive(0, 32'h0, 2'b00, 0, 1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      #1;
      check($sformatf("sat hold %0d", i), 64'(stall_cycles), 64'(15));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
